// File: rtl/core_irq_pkg.sv
// rtl/core_irq_pkg.sv - shared sizes, reset flag values and FSM encoding for the IRQ dispatcher
package core_irq_pkg;

  localparam int P_ENTRY_N = 64;
  localparam int P_ENTRY_W = 6;
  localparam int LEVEL_W   = 2;

  localparam logic               VALID_RST = 1'b0;
  localparam logic               MASK_RST  = 1'b1;
  localparam logic [LEVEL_W-1:0] LEVEL_RST = 2'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/core_irq_dispatcher_if.sv
// rtl/core_irq_dispatcher_if.sv - core-side config-table write port and interrupt offer handshake
interface core_irq_dispatcher_if;
  import core_irq_pkg::*;

  logic                 iIRQ_CONFIG_TABLE_REQ;
  logic [P_ENTRY_W-1:0] iIRQ_CONFIG_TABLE_ENTRY;
  logic                 iIRQ_CONFIG_TABLE_FLAG_MASK;
  logic                 iIRQ_CONFIG_TABLE_FLAG_VALID;
  logic [LEVEL_W-1:0]   iIRQ_CONFIG_TABLE_FLAG_LEVEL;
  logic                 oINTERRUPT_VALID;
  logic [P_ENTRY_W-1:0] oINTERRUPT_NUM;
  logic                 iINTERRUPT_ACK;

  modport master (
    output iIRQ_CONFIG_TABLE_REQ, iIRQ_CONFIG_TABLE_ENTRY, iIRQ_CONFIG_TABLE_FLAG_MASK,
           iIRQ_CONFIG_TABLE_FLAG_VALID, iIRQ_CONFIG_TABLE_FLAG_LEVEL, iINTERRUPT_ACK,
    input  oINTERRUPT_VALID, oINTERRUPT_NUM
  );

  modport slave (
    input  iIRQ_CONFIG_TABLE_REQ, iIRQ_CONFIG_TABLE_ENTRY, iIRQ_CONFIG_TABLE_FLAG_MASK,
           iIRQ_CONFIG_TABLE_FLAG_VALID, iIRQ_CONFIG_TABLE_FLAG_LEVEL, iINTERRUPT_ACK,
    output oINTERRUPT_VALID, oINTERRUPT_NUM
  );

endinterface

// File: rtl/core_irq_priority_select.sv
// rtl/core_irq_priority_select.sv - combinational pairwise tree picking highest level, then lowest index
module core_irq_priority_select
  import core_irq_pkg::*;
(
  input  logic [P_ENTRY_N-1:0]              eligible,
  input  logic [P_ENTRY_N-1:0][LEVEL_W-1:0] level,
  output logic                              found,
  output logic [P_ENTRY_W-1:0]              num
);

  always_comb begin : tree
    logic                 nodeFound [P_ENTRY_N];
    logic [LEVEL_W-1:0]   nodeLevel [P_ENTRY_N];
    logic [P_ENTRY_W-1:0] nodeNum   [P_ENTRY_N];
    for (int i = 0; i < P_ENTRY_N; i++) begin
      nodeFound[i] = eligible[i];
      nodeLevel[i] = level[i];
      nodeNum[i]   = P_ENTRY_W'(i);
    end
    // Reduce in place: node j of each pass merges nodes 2j (lower indices) and 2j+1.
    for (int span = P_ENTRY_N / 2; span >= 1; span = span / 2) begin
      for (int j = 0; j < span; j++) begin
        if (nodeFound[2*j+1] && (!nodeFound[2*j] || (nodeLevel[2*j+1] > nodeLevel[2*j]))) begin
          nodeFound[j] = 1'b1;
          nodeLevel[j] = nodeLevel[2*j+1];
          nodeNum[j]   = nodeNum[2*j+1];
        end else begin
          nodeFound[j] = nodeFound[2*j];
          nodeLevel[j] = nodeLevel[2*j];
          nodeNum[j]   = nodeNum[2*j];
        end
      end
    end
    found = nodeFound[0];
    num   = nodeNum[0];
  end

endmodule

// File: rtl/core_irq_dispatcher.sv
// rtl/core_irq_dispatcher.sv - IRQ config table, pending latch and one-at-a-time offer to the core
module core_irq_dispatcher
  import core_irq_pkg::*;
(
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic [P_ENTRY_N-1:0] iDEVICE_IRQ,
  output logic                 oPENDING_ANY,
  core_irq_dispatcher_if.slave irqBus
);

  logic [P_ENTRY_N-1:0]              entryValid;
  logic [P_ENTRY_N-1:0]              entryMask;
  logic [P_ENTRY_N-1:0][LEVEL_W-1:0] entryLevel;
  logic [P_ENTRY_N-1:0]              pending;
  logic [P_ENTRY_N-1:0]              pendingNext;
  logic [P_ENTRY_N-1:0]              eligible;
  state_t                            state;
  state_t                            stateNext;
  logic [P_ENTRY_W-1:0]              offerNum;
  logic [P_ENTRY_W-1:0]              offerNumNext;
  logic                              winnerFound;
  logic [P_ENTRY_W-1:0]              winnerNum;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      entryValid <= {P_ENTRY_N{VALID_RST}};
      entryMask  <= {P_ENTRY_N{MASK_RST}};
      entryLevel <= {P_ENTRY_N{LEVEL_RST}};
    end else if (irqBus.iIRQ_CONFIG_TABLE_REQ) begin
      entryValid[irqBus.iIRQ_CONFIG_TABLE_ENTRY] <= irqBus.iIRQ_CONFIG_TABLE_FLAG_VALID;
      entryMask[irqBus.iIRQ_CONFIG_TABLE_ENTRY]  <= irqBus.iIRQ_CONFIG_TABLE_FLAG_MASK;
      entryLevel[irqBus.iIRQ_CONFIG_TABLE_ENTRY] <= irqBus.iIRQ_CONFIG_TABLE_FLAG_LEVEL;
    end
  end

  // Order matters: a new event beats the ack clear, an invalidating write beats a new event.
  always_comb begin
    pendingNext = pending;
    if ((state == OFFER) && irqBus.iINTERRUPT_ACK) begin
      pendingNext[offerNum] = 1'b0;
    end
    pendingNext = pendingNext | (iDEVICE_IRQ & entryValid);
    if (irqBus.iIRQ_CONFIG_TABLE_REQ && !irqBus.iIRQ_CONFIG_TABLE_FLAG_VALID) begin
      pendingNext[irqBus.iIRQ_CONFIG_TABLE_ENTRY] = 1'b0;
    end
  end

  assign eligible = pending & entryValid & ~entryMask;

  core_irq_priority_select uSelect (
    .eligible (eligible),
    .level    (entryLevel),
    .found    (winnerFound),
    .num      (winnerNum)
  );

  always_comb begin
    stateNext    = state;
    offerNumNext = offerNum;
    case (state)
      IDLE: begin
        if (winnerFound) begin
          stateNext    = OFFER;
          offerNumNext = winnerNum;
        end
      end
      OFFER: begin
        if (irqBus.iINTERRUPT_ACK) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state        <= IDLE;
      offerNum     <= '0;
      pending      <= '0;
      oPENDING_ANY <= 1'b0;
    end else begin
      state        <= stateNext;
      offerNum     <= offerNumNext;
      pending      <= pendingNext;
      oPENDING_ANY <= |pending;
    end
  end

  assign irqBus.oINTERRUPT_VALID = (state == OFFER);
  assign irqBus.oINTERRUPT_NUM   = offerNum;

endmodule

// File: tb/tb_core_irq_dispatcher.sv
// tb/tb_core_irq_dispatcher.sv - directed self-checking bench for core_irq_dispatcher
module tb_core_irq_dispatcher;
  import core_irq_pkg::*;

  logic                 clk;
  logic                 rstN;
  logic [P_ENTRY_N-1:0] devIrq;
  logic                 pendingAny;
  int                   total;
  int                   bad;

  core_irq_dispatcher_if irqBus ();

  core_irq_dispatcher dut (
    .iCLOCK       (clk),
    .inRESET      (rstN),
    .iDEVICE_IRQ  (devIrq),
    .oPENDING_ANY (pendingAny),
    .irqBus       (irqBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int entry, input logic mask, input logic valid, input int level);
    irqBus.iIRQ_CONFIG_TABLE_REQ        = 1'b1;
    irqBus.iIRQ_CONFIG_TABLE_ENTRY      = P_ENTRY_W'(entry);
    irqBus.iIRQ_CONFIG_TABLE_FLAG_MASK  = mask;
    irqBus.iIRQ_CONFIG_TABLE_FLAG_VALID = valid;
    irqBus.iIRQ_CONFIG_TABLE_FLAG_LEVEL = LEVEL_W'(level);
    tick();
    irqBus.iIRQ_CONFIG_TABLE_REQ = 1'b0;
  endtask

  task automatic pulse(input int idx);
    devIrq = '0;
    devIrq[idx] = 1'b1;
    tick();
    devIrq = '0;
  endtask

  task automatic ackOnce();
    irqBus.iINTERRUPT_ACK = 1'b1;
    tick();
    irqBus.iINTERRUPT_ACK = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick();
    tick();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    total++; if (irqBus.oINTERRUPT_NUM !== 6'd0) begin bad++; $display("FAIL reset_num got=%0d want=0", irqBus.oINTERRUPT_NUM); end
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL reset_pending got=%0b want=0", pendingAny); end
    rstN = 1'b1;
    tick();
    pulse(3);
    tick();
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL invalid_drop_pending got=%0b want=0", pendingAny); end
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL invalid_drop_valid got=%0b want=0", irqBus.oINTERRUPT_VALID); end
  endtask

  task automatic test_basic();
    cfg(5, 1'b0, 1'b1, 1);
    pulse(5);
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    tick();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", irqBus.oINTERRUPT_VALID); end
    total++; if (irqBus.oINTERRUPT_NUM !== 6'd5) begin bad++; $display("FAIL basic_num got=%0d want=5", irqBus.oINTERRUPT_NUM); end
    total++; if (pendingAny !== 1'b1) begin bad++; $display("FAIL basic_pending got=%0b want=1", pendingAny); end
    ackOnce();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL basic_ack_drop got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    tick();
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL basic_pending_clr got=%0b want=0", pendingAny); end
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL basic_no_reoffer got=%0b want=0", irqBus.oINTERRUPT_VALID); end
  endtask

  task automatic test_priority();
    int order [3];
    order = '{20, 30, 10};
    cfg(10, 1'b0, 1'b1, 1);
    cfg(20, 1'b0, 1'b1, 3);
    cfg(30, 1'b0, 1'b1, 3);
    devIrq = '0;
    devIrq[10] = 1'b1;
    devIrq[20] = 1'b1;
    devIrq[30] = 1'b1;
    tick();
    devIrq = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== P_ENTRY_W'(order[k]))) begin
        bad++; $display("FAIL prio_offer%0d got=v%0b/n%0d want=v1/n%0d", k, irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM, order[k]);
      end
      ackOnce();
      total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL prio_gap%0d got=%0b want=0", k, irqBus.oINTERRUPT_VALID); end
    end
    tick();
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL prio_drained got=%0b want=0", pendingAny); end
  endtask

  task automatic test_mask();
    cfg(7, 1'b1, 1'b1, 2);
    pulse(7);
    tick();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL mask_no_offer got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    total++; if (pendingAny !== 1'b1) begin bad++; $display("FAIL mask_pending got=%0b want=1", pendingAny); end
    cfg(7, 1'b0, 1'b1, 2);
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL mask_unmask_early got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    tick();
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd7)) begin
      bad++; $display("FAIL mask_unmask_offer got=v%0b/n%0d want=v1/n7", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    ackOnce();
    tick();
  endtask

  task automatic test_stability();
    cfg(4, 1'b0, 1'b1, 0);
    cfg(2, 1'b0, 1'b1, 3);
    pulse(4);
    tick();
    total++; if (irqBus.oINTERRUPT_NUM !== 6'd4) begin bad++; $display("FAIL stab_first got=%0d want=4", irqBus.oINTERRUPT_NUM); end
    pulse(2);
    tick();
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd4)) begin
      bad++; $display("FAIL stab_hold got=v%0b/n%0d want=v1/n4", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    cfg(4, 1'b1, 1'b1, 0);
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd4)) begin
      bad++; $display("FAIL stab_remask got=v%0b/n%0d want=v1/n4", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    ackOnce();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL stab_gap got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    tick();
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd2)) begin
      bad++; $display("FAIL stab_next got=v%0b/n%0d want=v1/n2", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    ackOnce();
    tick();
  endtask

  task automatic test_ack_reevent();
    cfg(9, 1'b0, 1'b1, 1);
    pulse(9);
    tick();
    total++; if (irqBus.oINTERRUPT_NUM !== 6'd9) begin bad++; $display("FAIL reev_first got=%0d want=9", irqBus.oINTERRUPT_NUM); end
    irqBus.iINTERRUPT_ACK = 1'b1;
    devIrq = '0;
    devIrq[9] = 1'b1;
    tick();
    irqBus.iINTERRUPT_ACK = 1'b0;
    devIrq = '0;
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL reev_gap got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    tick();
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd9)) begin
      bad++; $display("FAIL reev_again got=v%0b/n%0d want=v1/n9", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    ackOnce();
    tick();
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL reev_drained got=%0b want=0", pendingAny); end
  endtask

  task automatic test_invalidate();
    cfg(12, 1'b1, 1'b1, 0);
    pulse(12);
    tick();
    total++; if (pendingAny !== 1'b1) begin bad++; $display("FAIL inval_pending got=%0b want=1", pendingAny); end
    cfg(12, 1'b0, 1'b0, 0);
    tick();
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL inval_clear got=%0b want=0", pendingAny); end
    tick();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL inval_no_offer got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    cfg(12, 1'b0, 1'b1, 0);
    devIrq = '0;
    devIrq[12] = 1'b1;
    cfg(12, 1'b0, 1'b0, 0);
    devIrq = '0;
    tick();
    tick();
    total++; if ((pendingAny !== 1'b0) || (irqBus.oINTERRUPT_VALID !== 1'b0)) begin
      bad++; $display("FAIL inval_clear_wins got=p%0b/v%0b want=p0/v0", pendingAny, irqBus.oINTERRUPT_VALID);
    end
    cfg(13, 1'b0, 1'b1, 2);
    pulse(13);
    tick();
    cfg(13, 1'b0, 1'b0, 2);
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd13)) begin
      bad++; $display("FAIL inval_offer_kept got=v%0b/n%0d want=v1/n13", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    tick();
    total++; if ((pendingAny !== 1'b0) || (irqBus.oINTERRUPT_VALID !== 1'b1)) begin
      bad++; $display("FAIL inval_offer_pend got=p%0b/v%0b want=p0/v1", pendingAny, irqBus.oINTERRUPT_VALID);
    end
    ackOnce();
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL inval_ack got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    tick();
  endtask

  task automatic test_reset_mid_offer();
    cfg(15, 1'b0, 1'b1, 1);
    cfg(16, 1'b0, 1'b1, 0);
    devIrq = '0;
    devIrq[15] = 1'b1;
    devIrq[16] = 1'b1;
    tick();
    devIrq = '0;
    tick();
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b1) || (irqBus.oINTERRUPT_NUM !== 6'd15)) begin
      bad++; $display("FAIL rst_pre_offer got=v%0b/n%0d want=v1/n15", irqBus.oINTERRUPT_VALID, irqBus.oINTERRUPT_NUM);
    end
    #1;
    rstN = 1'b0;
    #1;
    total++; if (irqBus.oINTERRUPT_VALID !== 1'b0) begin bad++; $display("FAIL rst_async_drop got=%0b want=0", irqBus.oINTERRUPT_VALID); end
    total++; if (pendingAny !== 1'b0) begin bad++; $display("FAIL rst_async_pending got=%0b want=0", pendingAny); end
    #1;
    rstN = 1'b1;
    tick();
    tick();
    total++; if ((irqBus.oINTERRUPT_VALID !== 1'b0) || (pendingAny !== 1'b0)) begin
      bad++; $display("FAIL rst_after got=v%0b/p%0b want=v0/p0", irqBus.oINTERRUPT_VALID, pendingAny);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rstN = 1'b0;
    devIrq = '0;
    irqBus.iIRQ_CONFIG_TABLE_REQ        = 1'b0;
    irqBus.iIRQ_CONFIG_TABLE_ENTRY      = '0;
    irqBus.iIRQ_CONFIG_TABLE_FLAG_MASK  = 1'b0;
    irqBus.iIRQ_CONFIG_TABLE_FLAG_VALID = 1'b0;
    irqBus.iIRQ_CONFIG_TABLE_FLAG_LEVEL = '0;
    irqBus.iINTERRUPT_ACK               = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_stability();
    test_ack_reevent();
    test_invalidate();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
